// File: rtl/i2s_frame_ctrl_if.sv
// Bus bundle for the I2S frame controller: producer handshake, status flags
// and the four I2S lines. The clock and reset stay plain ports on the module.
interface i2s_frame_ctrl_if;
  logic        enable;
  logic [23:0] l_sample;
  logic [23:0] r_sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        underrun_clr;
  logic        underrun;
  logic        frame_stb;
  logic        i2s_mclk;
  logic        i2s_bick;
  logic        i2s_lrck;
  logic        i2s_sdti;

  modport master (
    output enable, l_sample, r_sample, sample_valid, underrun_clr,
    input  sample_ready, underrun, frame_stb,
    input  i2s_mclk, i2s_bick, i2s_lrck, i2s_sdti
  );

  modport slave (
    input  enable, l_sample, r_sample, sample_valid, underrun_clr,
    output sample_ready, underrun, frame_stb,
    output i2s_mclk, i2s_bick, i2s_lrck, i2s_sdti
  );
endinterface

// File: rtl/i2s_frame_ctrl.sv
// I2S transmitter: 9-bit divider from the master clock, 2-deep FIFO of stereo
// pairs, one pair latched per 512-cycle frame and shifted out MSB first.
module i2s_frame_ctrl (
  input  logic            clk_i2s_i,
  input  logic            nreset_i,
  i2s_frame_ctrl_if.slave bus
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } pair_t;

  localparam logic [8:0] DIV_LAST   = 9'd511;
  localparam logic [1:0] FIFO_DEPTH = 2'd2;
  localparam logic [4:0] SLOT_FIRST = 5'd1;
  localparam logic [4:0] SLOT_LAST  = 5'd24;

  // Run control and divider
  run_state_e state_q, state_d;
  logic [8:0] div_q, div_d;
  logic       frame_start;

  // Sample buffer
  pair_t      fifo_mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  // Frame register, serializer and status
  pair_t       frame_q, frame_d;
  logic        sdti_q, sdti_d;
  logic        underrun_q, underrun_d;
  logic        frame_stb_q, frame_stb_d;
  logic [4:0]  slot;
  logic [4:0]  bit_idx;
  logic [23:0] word;
  logic        slot_bit;

  // ---------------------------------------------------------------------------
  // Run/stop FSM. A frame starts on the divider wrap, or on the very first
  // enabled edge after a stop (the divider is then sitting at 0).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    div_d       = '0;
    frame_start = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (bus.enable) begin
          state_d     = ST_RUN;
          div_d       = div_q + 9'd1;
          frame_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.enable) begin
          div_d       = div_q + 9'd1;
          frame_start = (div_q == DIV_LAST);
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO control. Pop decisions use the registered count only, so a push in
  // the same cycle as a frame start never feeds the frame directly.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_full  = (count_q == FIFO_DEPTH);
    fifo_empty = (count_q == 2'd0);
    push       = bus.sample_valid && !fifo_full;
    pop        = frame_start && !fifo_empty;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Frame register reloads only on a pop; an empty FIFO repeats the old pair.
  always_comb begin
    frame_d     = pop ? fifo_mem_q[rd_ptr_q] : frame_q;
    frame_stb_d = frame_start;
    if (frame_start && fifo_empty) begin
      underrun_d = 1'b1;
    end else if (bus.underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer. SDTI is reloaded when the next divider value lands on a slot
  // boundary, i.e. together with the BICK falling edge. The slot bit is taken
  // from the frame register as it stands before any reload on that edge; the
  // only boundary shared with a reload is slot 0, which always drives 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    slot     = div_d[7:3];
    bit_idx  = SLOT_LAST - slot;
    word     = div_d[8] ? frame_q.right : frame_q.left;
    slot_bit = 1'b0;
    if ((slot >= SLOT_FIRST) && (slot <= SLOT_LAST)) begin
      slot_bit = word[bit_idx];
    end
    sdti_d = sdti_q;
    if (!bus.enable) begin
      sdti_d = 1'b0;
    end else if (div_d[2:0] == 3'd0) begin
      sdti_d = slot_bit;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i2s_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= ST_STOP;
      div_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
      frame_q     <= '0;
      sdti_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_stb_q <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      div_q       <= div_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      sdti_q      <= sdti_d;
      underrun_q  <= underrun_d;
      frame_stb_q <= frame_stb_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count guard it, so stale words are never read.
  always_ff @(posedge clk_i2s_i) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= '{left: bus.l_sample, right: bus.r_sample};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. BICK and LRCK are gated by ENABLE so they drop in the same cycle
  // the run request goes away, before the divider clears on the next edge.
  // ---------------------------------------------------------------------------
  assign bus.sample_ready = !fifo_full;
  assign bus.underrun     = underrun_q;
  assign bus.frame_stb    = frame_stb_q;
  assign bus.i2s_mclk     = clk_i2s_i;
  assign bus.i2s_bick     = bus.enable & div_q[2];
  assign bus.i2s_lrck     = bus.enable & div_q[8];
  assign bus.i2s_sdti     = sdti_q;

  a_count_bound : assert property (
    @(posedge clk_i2s_i) disable iff (!nreset_i) count_q <= FIFO_DEPTH
  );

  a_stopped_div_zero : assert property (
    @(posedge clk_i2s_i) disable iff (!nreset_i) (state_q == ST_STOP) |-> (div_q == 9'd0)
  );

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Self-checking bench for i2s_frame_ctrl: frame-level vector table decoded from
// the serial line, hand sequences for corner cases, and a random run vs. a model.
module tb_i2s_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2s_frame_ctrl_if bus ();

  i2s_frame_ctrl dut (
    .clk_i2s_i(clk),
    .nreset_i (rst_n),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: cycle count since run start, queue of pending pairs,
  // the pair on air, and the expected status flags.
  int unsigned m_n;
  logic [47:0] m_q[$];
  logic [47:0] m_cur;
  logic        m_underrun;
  logic        m_stb;

  typedef struct {
    bit          push;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    logic        exp_underrun;
  } frame_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n        = 0;
    m_q        = {};
    m_cur      = '0;
    m_underrun = 1'b0;
    m_stb      = 1'b0;
  endtask

  task automatic model_edge();
    int  sz;
    bit  fs;
    sz = m_q.size();
    if (bus.enable) m_n = m_n + 1;
    else            m_n = 0;
    fs = bus.enable && ((m_n == 1) || (m_n % 512 == 0));
    if (fs && sz == 0)          m_underrun = 1'b1;
    else if (bus.underrun_clr)  m_underrun = 1'b0;
    if (fs && sz > 0) m_cur = m_q.pop_front();
    if (bus.sample_valid && sz < 2) m_q.push_back({bus.l_sample, bus.r_sample});
    m_stb = fs;
  endtask

  function automatic logic [5:0] model_out();
    int          d;
    int          slot;
    logic [23:0] w;
    logic        b, bk, lr;
    d    = int'(m_n % 512);
    bk   = bus.enable && ((d / 4) % 2 == 1);
    lr   = bus.enable && (d >= 256);
    w    = (d >= 256) ? m_cur[23:0] : m_cur[47:24];
    slot = (d % 256) / 8;
    b    = (bus.enable && slot >= 1 && slot <= 24) ? w[24 - slot] : 1'b0;
    return {m_q.size() < 2, m_underrun, m_stb, bk, lr, b};
  endfunction

  function automatic logic [5:0] bus_outs();
    return {bus.sample_ready, bus.underrun, bus.frame_stb,
            bus.i2s_bick, bus.i2s_lrck, bus.i2s_sdti};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cycle", 64'(bus_outs()), 64'(model_out()));
  endtask

  task automatic apply_reset();
    bus.enable       = 1'b0;
    bus.sample_valid = 1'b0;
    bus.underrun_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_outputs", 64'(bus_outs()), 64'(6'b100000));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release", 64'(bus_outs()), 64'(6'b100000));
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    bus.l_sample     = l;
    bus.r_sample     = r;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_stb();
    int g;
    g = 0;
    while (bus.frame_stb !== 1'b1 && g < 1100) begin
      tick();
      g++;
    end
    check("stb_wait", 64'(bus.frame_stb), 64'(1'b1));
  endtask

  task automatic wait_div(input int target);
    int g;
    g = 0;
    while (int'(m_n % 512) != target && g < 1100) begin
      tick();
      g++;
    end
  endtask

  // Receiver: after a frame strobe, sample SDTI on 64 BICK rising edges.
  task automatic capture_frame(output logic [23:0] l, output logic [23:0] r,
                               output logic pad_zero, output logic ur);
    logic [31:0] lw, rw;
    logic        pb;
    int          bitn, g, lr_bad;
    lw = '0;
    rw = '0;
    wait_stb();
    ur     = bus.underrun;
    pb     = bus.i2s_bick;
    bitn   = 0;
    g      = 0;
    lr_bad = 0;
    while (bitn < 64 && g < 600) begin
      tick();
      g++;
      if (bus.i2s_bick && !pb) begin
        if (bitn < 32) begin
          lw[31 - bitn] = bus.i2s_sdti;
          if (bus.i2s_lrck !== 1'b0) lr_bad++;
        end else begin
          rw[63 - bitn] = bus.i2s_sdti;
          if (bus.i2s_lrck !== 1'b1) lr_bad++;
        end
        bitn++;
      end
      pb = bus.i2s_bick;
    end
    check("capture_len", 64'(bitn), 64'(64));
    check("capture_lrck", 64'(lr_bad), 64'(0));
    l        = lw[30:7];
    r        = rw[30:7];
    pad_zero = (lw[31] == 1'b0) && (lw[6:0] == 7'd0) && (rw[31] == 1'b0) && (rw[6:0] == 7'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t  vecs[4];
    logic [23:0] got_l, got_r;
    logic        got_pad, got_ur;
    int          bad_bick, bad_lrck, bad_stb, bad_sdti, n_bick, n_lrck, n_stb, n_tog;
    int          last_bick, last_lrck, last_stb, stop_bad;
    logic        pb, pl, psd;
    int unsigned push_period;

    vecs[0] = '{push: 1'b1, l: 24'h800001, r: 24'h7FFFFE, exp_l: 24'h800001, exp_r: 24'h7FFFFE, exp_underrun: 1'b0};
    vecs[1] = '{push: 1'b1, l: 24'h123456, r: 24'hABCDEF, exp_l: 24'h123456, exp_r: 24'hABCDEF, exp_underrun: 1'b0};
    vecs[2] = '{push: 1'b0, l: 24'h000000, r: 24'h000000, exp_l: 24'h123456, exp_r: 24'hABCDEF, exp_underrun: 1'b1};
    vecs[3] = '{push: 1'b1, l: 24'h000000, r: 24'hFFFFFF, exp_l: 24'h000000, exp_r: 24'hFFFFFF, exp_underrun: 1'b1};

    bus.enable       = 1'b0;
    bus.l_sample     = '0;
    bus.r_sample     = '0;
    bus.sample_valid = 1'b0;
    bus.underrun_clr = 1'b0;
    rst_n            = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Frame-level vectors, decoded from the serial line
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].push) push_pair(vecs[i].l, vecs[i].r);
      if (i == 0) bus.enable = 1'b1;
      capture_frame(got_l, got_r, got_pad, got_ur);
      check($sformatf("vec%0d_left", i), 64'(got_l), 64'(vecs[i].exp_l));
      check($sformatf("vec%0d_right", i), 64'(got_r), 64'(vecs[i].exp_r));
      check($sformatf("vec%0d_pad_zero", i), 64'(got_pad), 64'(1'b1));
      check($sformatf("vec%0d_underrun", i), 64'(got_ur), 64'(vecs[i].exp_underrun));
    end

    // Underrun clear, then clear coincident with a new underrun
    bus.underrun_clr = 1'b1;
    tick();
    bus.underrun_clr = 1'b0;
    check("underrun_cleared", 64'(bus.underrun), 64'(1'b0));
    wait_div(511);
    bus.underrun_clr = 1'b1;
    tick();
    bus.underrun_clr = 1'b0;
    check("clr_vs_set_underrun", 64'(bus.underrun), 64'(1'b1));
    check("clr_vs_set_stb", 64'(bus.frame_stb), 64'(1'b1));

    // Clock ratios and SDTI transition placement
    push_pair(24'h5A5A5A, 24'hA5C3F0);
    bad_bick = 0; bad_lrck = 0; bad_stb = 0; bad_sdti = 0;
    n_bick = 0; n_lrck = 0; n_stb = 0; n_tog = 0;
    last_bick = -1; last_lrck = -1; last_stb = -1;
    pb = bus.i2s_bick; pl = bus.i2s_lrck; psd = bus.i2s_sdti;
    for (int k = 0; k < 1100; k++) begin
      tick();
      if (bus.i2s_bick && !pb) begin
        if (last_bick >= 0 && k - last_bick != 8) bad_bick++;
        last_bick = k;
        n_bick++;
      end
      if (bus.i2s_lrck && !pl) begin
        if (last_lrck >= 0 && k - last_lrck != 512) bad_lrck++;
        last_lrck = k;
        n_lrck++;
      end
      if (bus.frame_stb) begin
        if (last_stb >= 0 && k - last_stb != 512) bad_stb++;
        last_stb = k;
        n_stb++;
      end
      if (bus.i2s_sdti !== psd) begin
        n_tog++;
        if (!(pb && !bus.i2s_bick)) bad_sdti++;
      end
      pb = bus.i2s_bick; pl = bus.i2s_lrck; psd = bus.i2s_sdti;
    end
    check("bick_period", 64'(bad_bick), 64'(0));
    check("lrck_period", 64'(bad_lrck), 64'(0));
    check("stb_period", 64'(bad_stb), 64'(0));
    check("sdti_on_bick_fall", 64'(bad_sdti), 64'(0));
    check("bick_seen", 64'(n_bick > 100), 64'(1'b1));
    check("lrck_seen", 64'(n_lrck >= 2), 64'(1'b1));
    check("stb_seen", 64'(n_stb >= 2), 64'(1'b1));
    check("sdti_toggles", 64'(n_tog > 0), 64'(1'b1));

    // FIFO fill while stopped, full back-pressure, ordered playback
    apply_reset();
    push_pair(24'h111111, 24'h222222);
    push_pair(24'h333333, 24'h444444);
    bus.l_sample     = 24'h555555;
    bus.r_sample     = 24'h666666;
    bus.sample_valid = 1'b1;
    check("third_offer_ready", 64'(bus.sample_ready), 64'(1'b0));
    tick();
    bus.sample_valid = 1'b0;
    bus.enable = 1'b1;
    wait_stb();
    check("ready_after_pop", 64'(bus.sample_ready), 64'(1'b1));
    capture_frame(got_l, got_r, got_pad, got_ur);
    check("fill_f1_left", 64'(got_l), 64'(24'h111111));
    check("fill_f1_right", 64'(got_r), 64'(24'h222222));
    capture_frame(got_l, got_r, got_pad, got_ur);
    check("fill_f2_left", 64'(got_l), 64'(24'h333333));
    check("fill_f2_right", 64'(got_r), 64'(24'h444444));

    // Stop mid-frame, restart from the next buffered pair
    push_pair(24'hC0FFEE, 24'h0BADF0);
    push_pair(24'hFEDCBA, 24'h13579B);
    wait_div(300);
    bus.enable = 1'b0;
    stop_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.i2s_bick !== 1'b0 || bus.i2s_lrck !== 1'b0 || bus.i2s_sdti !== 1'b0) stop_bad++;
    end
    check("stop_lines_low", 64'(stop_bad), 64'(0));
    bus.enable = 1'b1;
    capture_frame(got_l, got_r, got_pad, got_ur);
    check("restart_left", 64'(got_l), 64'(24'hFEDCBA));
    check("restart_right", 64'(got_r), 64'(24'h13579B));
    check("restart_pad_zero", 64'(got_pad), 64'(1'b1));

    // Reset mid-frame with two pairs buffered
    wait_div(10);
    push_pair(24'hAAAAAA, 24'hBBBBBB);
    push_pair(24'hCCCCCC, 24'hDDDDDD);
    wait_div(100);
    apply_reset();
    push_pair(24'h0F0F0F, 24'hF0F0F0);
    bus.enable = 1'b1;
    capture_frame(got_l, got_r, got_pad, got_ur);
    check("post_reset_left", 64'(got_l), 64'(24'h0F0F0F));
    check("post_reset_right", 64'(got_r), 64'(24'hF0F0F0));
    check("post_reset_underrun", 64'(got_ur), 64'(1'b0));

    // Random traffic against the model
    apply_reset();
    bus.enable = 1'b1;
    for (int k = 0; k < 8000; k++) begin
      push_period      = (k < 3000) ? 3 : ((k < 5500) ? 700 : 40);
      bus.sample_valid = ($urandom_range(push_period - 1, 0) == 0);
      bus.l_sample     = 24'($urandom);
      bus.r_sample     = 24'($urandom);
      bus.underrun_clr = ($urandom_range(299, 0) == 0);
      if ($urandom_range(1999, 0) == 0) bus.enable = ~bus.enable;
      tick();
    end
    bus.sample_valid = 1'b0;
    bus.underrun_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_frame_ctrl.md
I2S_FRAME_CTRL -- requirements
Module: i2s_frame_ctrl

Interface
REQ-001 SHALL have parameter: none; all timing ratios fixed as below.
REQ-002 CLK_I2S  input  1  master audio clock; all logic on rising edge.
REQ-003 nRESET  input  1  asynchronous active-low reset.
REQ-004 ENABLE  input  1  run/stop for serial clock generation.
REQ-005 L_SAMPLE  input  24  left sample, two's complement.
REQ-006 R_SAMPLE  input  24  right sample, two's complement.
REQ-007 SAMPLE_VALID  input  1  producer offers {L_SAMPLE,R_SAMPLE}.
REQ-008 SAMPLE_READY  output  1  buffer can accept a pair.
REQ-009 UNDERRUN_CLR  input  1  clears UNDERRUN flag.
REQ-010 UNDERRUN  output  1  sticky, frame started with empty buffer.
REQ-011 FRAME_STB  output  1  one-cycle pulse at each frame start.
REQ-012 I2S_MCLK, I2S_BICK, I2S_LRCK, I2S_SDTI  output  1 each  I2S bus.

Function
REQ-013 9-bit divider DIV increments by 1 each CLK_I2S while ENABLE=1, wraps 511->0; held at 0 while ENABLE=0.
REQ-014 I2S_MCLK = CLK_I2S; I2S_BICK = DIV[2] (MCLK/8); I2S_LRCK = DIV[8] (MCLK/512, 0=left, 1=right); both forced 0 while ENABLE=0.
REQ-015 Bit slot = DIV[7:3] (0..31 per channel, 64 BICK per frame).
REQ-016 I2S_SDTI is registered and changes only on the clock edge where DIV[2:0] becomes 0 (BICK falling edge).
REQ-017 Per channel: slot 0 drives 0; slots 1..24 drive word bits 23..0 (MSB first, one-BICK I2S delay); slots 25..31 drive 0.
REQ-018 Left word during LRCK=0, right word during LRCK=1, both from the same frame register.
REQ-019 Buffer: 2-entry FIFO of 48-bit pairs; SAMPLE_READY = not full (combinational from registered count).
REQ-020 Push occurs on a rising edge with SAMPLE_VALID=1 and SAMPLE_READY=1; no push when full.
REQ-021 Frame start = edge where DIV advances 511->0 with ENABLE=1, plus first edge after ENABLE rises (DIV 0->1 is not a frame start; loading occurs on the ENABLE=1 edge with DIV=0).
REQ-022 At frame start: if FIFO non-empty, pop head into frame register; FRAME_STB=1 for that cycle.
REQ-023 At frame start with FIFO empty: frame register holds previous pair (repeat), UNDERRUN set, FRAME_STB still pulses.
REQ-024 Simultaneous push and frame start with FIFO empty: pop sees empty (underrun per REQ-023), pushed pair stored, count=1.
REQ-025 Simultaneous push and pop with count=1: count stays 1, order preserved.
REQ-026 UNDERRUN_CLR=1 clears UNDERRUN; if a set condition occurs the same cycle, set wins.
REQ-027 ENABLE falling mid-frame: DIV resets to 0 next edge, SDTI driven 0, FIFO contents and frame register kept.
REQ-028 Frame register updates never affect bits already shifted; the new pair first appears at left slot 1 of the new frame.

Reset
REQ-029 On nRESET=0: DIV=0, FIFO empty, frame register=0, SDTI=0, UNDERRUN=0, FRAME_STB=0; SAMPLE_READY=1.
REQ-030 Reset asserted mid-frame aborts the frame immediately; release resumes with DIV=0 and no stale data.

Verification
REQ-031 Push L=0x800001, R=0x7FFFFE, ENABLE=1 -> left slots 1..24 = 1000..0001, right slots 1..24 = 0111..1110, slots 0 and 25..31 = 0.
REQ-032 Push 3 pairs back-to-back from reset with ENABLE=0 -> third offer sees SAMPLE_READY=0; after ENABLE, frames 1,2 output in order, ready returns 1 after first pop.
REQ-033 No push after one frame -> second frame repeats pair, UNDERRUN=1 until UNDERRUN_CLR pulse; CLR coincident with another underrun leaves UNDERRUN=1.
REQ-034 Check clock ratios: BICK period 8 MCLK, LRCK period 512 MCLK, FRAME_STB every 512 cycles, SDTI transitions only when BICK falls.
REQ-035 Deassert ENABLE at DIV=300, reassert 10 cycles later -> BICK/LRCK/SDTI low during stop, new frame starts cleanly from next FIFO entry.
REQ-036 nRESET pulse at DIV=100 with 2 pairs buffered -> all outputs at reset values, FIFO empty, UNDERRUN=0 after release.
